fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port StallF  input  1  hazard-unit fetch stall.
REQ-005 SHALL have port StallD  input  1  hazard-unit decode stall; IF/ID register holds.
REQ-006 SHALL have port PCSrcD  input  1  taken branch resolved in decode.
REQ-007 SHALL have port JumpD  input  1  jump in decode.
REQ-008 SHALL have port PCBranchD  input  32  branch target.
REQ-009 SHALL have port imem_req  output  1  instruction-memory request.
REQ-010 SHALL have port imem_addr  output  32  fetch address.
REQ-011 SHALL have port imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-013 SHALL have port InstrD  output  32  IF/ID instruction; feeds OpD=[31:26], FunctD=[5:0], RsD=[25:21], RtD=[20:16].
REQ-014 SHALL have port PCPlus4D  output  32  IF/ID PC+4.
REQ-015 SHALL have port ValidD  output  1  InstrD holds a real instruction (0 = bubble).
REQ-016 SHALL have port FetchBusyF  output  1  fetch waiting on memory or discarding a stale access.

Function
REQ-017 SHALL keep a 32-bit register PCF, a 32-bit register RedirPC and a 2-state FSM {FETCH, KILL}.
REQ-018 SHALL drive imem_req=1 whenever reset=0 and imem_addr=PCF in both states; imem_addr SHALL stay constant until a cycle with imem_ready=1.
REQ-019 SHALL define redirect = (PCSrcD | JumpD) & ~StallD; redirect is ignored while StallD=1.
REQ-020 SHALL select target = JumpD ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} : PCBranchD (JumpD wins if both set).
REQ-021 SHALL define deliver = (state==FETCH) & imem_ready & ~StallF & ~redirect.
REQ-022 FETCH, deliver: PCF <= PCF+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-023 FETCH, redirect & imem_ready: PCF <= target, stay FETCH, response discarded.
REQ-024 FETCH, redirect & ~imem_ready: RedirPC <= target, go KILL, PCF unchanged.
REQ-025 FETCH, imem_ready & StallF & ~redirect: PCF holds, response discarded, same address re-presented next cycle.
REQ-026 KILL: PCF holds; on imem_ready PCF <= RedirPC, go FETCH, response discarded; a redirect while in KILL SHALL overwrite RedirPC.
REQ-027 IF/ID SHALL update: StallD=1 -> hold all of InstrD/PCPlus4D/ValidD; else redirect -> bubble; else deliver -> InstrD<=imem_rdata, PCPlus4D<=PCF+4, ValidD<=1; else bubble.
REQ-028 Bubble SHALL be InstrD=32'h0000_0000 (sll $0 NOP), ValidD=0, PCPlus4D unchanged.
REQ-029 Fetch-to-decode latency SHALL be one cycle after the imem_ready cycle; zero-wait memory sustains one instruction per cycle.
REQ-030 FetchBusyF SHALL be combinational: (state==FETCH & ~imem_ready) | (state==KILL).

Reset
REQ-031 With reset=1 at a rising edge: PCF=RESET_PC, RedirPC=0, state=FETCH, InstrD=0, PCPlus4D=0, ValidD=0.
REQ-032 While reset=1, imem_req SHALL be 0; reset mid-access or in KILL SHALL abandon the access and the pending redirect.
REQ-033 First request after reset deassertion SHALL be imem_addr=RESET_PC in the same cycle.

Verification
REQ-034 Zero-wait stream, imem_ready=1 always, words W0..W3 -> imem_addr 0,4,8,C on consecutive cycles; InstrD=W0..W3 one cycle later, ValidD=1, PCPlus4D=4,8,C,10.
REQ-035 Two wait states at 0x8 -> imem_addr held at 0x8 for 3 cycles, FetchBusyF=1 for 2, two bubbles (ValidD=0, InstrD=0), then InstrD=word@0x8.
REQ-036 PCSrcD=1, PCBranchD=0x40, imem_ready=1 -> next imem_addr=0x40, next InstrD is a bubble, word at old PCF never reaches decode.
REQ-037 JumpD=1, ready=0 on pending access at 0x10, InstrD[25:0]=26'h000_0100 -> FSM KILL, addr held 0x10 until ready, then imem_addr=0x400, discarded word not in decode.
REQ-038 StallF=StallD=1 for 2 cycles with ready=1 -> PCF, InstrD, PCPlus4D, ValidD unchanged; PCSrcD asserted during stall has no effect.
REQ-039 reset pulsed while in KILL -> next cycle imem_addr=RESET_PC, state FETCH, ValidD=0, stored redirect lost.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for a five-stage MIPS-style pipeline.
// A KILL state waits out an in-flight access that was overtaken by a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusyF
);

    typedef enum logic {
        FETCH,
        KILL
    } FetchState;

    FetchState   state;
    FetchState   stateNext;
    logic [31:0] PCF;
    logic [31:0] pcNext;
    logic [31:0] RedirPC;
    logic [31:0] redirNext;
    logic [31:0] pcPlus4F;
    logic [31:0] target;
    logic        redirect;
    logic        deliver;

    // A stalled decode stage must not act on its own branch/jump yet.
    assign redirect = (PCSrcD | JumpD) & ~StallD;
    assign target   = JumpD ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} : PCBranchD;
    assign pcPlus4F = PCF + 32'd4;
    assign deliver  = (state == FETCH) & imem_ready & ~StallF & ~redirect;

    assign imem_req   = ~reset;
    assign imem_addr  = PCF;
    assign FetchBusyF = ((state == FETCH) & ~imem_ready) | (state == KILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            PCF     <= RESET_PC;
            RedirPC <= 32'h0000_0000;
        end else begin
            state   <= stateNext;
            PCF     <= pcNext;
            RedirPC <= redirNext;
        end
    end

    // The address on the bus must not change until memory answers, so an early
    // redirect is parked in RedirPC and applied when the stale word arrives.
    always_comb begin
        stateNext = state;
        pcNext    = PCF;
        redirNext = RedirPC;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pcNext = target;
                    end else begin
                        redirNext = target;
                        stateNext = KILL;
                    end
                end else if (deliver) begin
                    pcNext = pcPlus4F;
                end
            end
            KILL: begin
                if (redirect) begin
                    redirNext = target;
                end
                if (imem_ready) begin
                    pcNext    = redirect ? target : RedirPC;
                    stateNext = FETCH;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    // Bubbles leave PCPlus4D alone so a held jump target base stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= 32'h0000_0000;
            PCPlus4D <= 32'h0000_0000;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (deliver) begin
            InstrD   <= imem_rdata;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= 32'h0000_0000;
            ValidD <= 1'b0;
        end
    end

endmodule
